// File: rtl/mat_stream_reader.sv
// Matrix RAM read sequencer: walks an n_rows x n_cols block in row- or column-major
// order, hides the RAM's 1-cycle read latency and re-emits elements on a valid/ready stream.
module mat_stream_reader #(
  parameter int ADDR_LEN = 6,
  parameter int DATA_LEN = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                start,
  input  logic [ADDR_LEN:0]   base_addr,
  input  logic [ADDR_LEN:0]   n_rows,
  input  logic [ADDR_LEN:0]   n_cols,
  input  logic                col_major,
  output logic [ADDR_LEN:0]   rd_addr,
  input  logic [DATA_LEN-1:0] rd_data,
  output logic [DATA_LEN-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last_line,
  output logic                out_last,
  output logic                busy,
  output logic                done
);
  localparam int AW = ADDR_LEN + 1;
  localparam logic [AW-1:0] ONE = AW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       addr_q, addr_d, row_q, row_d, col_q, col_d;
  logic [AW-1:0]       base_q, base_d, nrows_q, nrows_d, ncols_q, ncols_d;
  logic                colmaj_q, colmaj_d;
  logic                tag_q, tag_d, tag_ll_q, tag_ll_d, tag_last_q, tag_last_d;
  logic [DATA_LEN-1:0] fdata_q [4];
  logic [DATA_LEN-1:0] fdata_d [4];
  logic [3:0]          fll_q, fll_d, flast_q, flast_d;
  logic [1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
  logic [2:0]          cnt_q, cnt_d;

  logic row_end, col_end, line_end, mat_end, issue, push, pop;

  assign rd_addr       = addr_q;
  assign out_valid     = (cnt_q != 3'd0);
  assign out_data      = fdata_q[rptr_q];
  assign out_last_line = fll_q[rptr_q];
  assign out_last      = flast_q[rptr_q];
  assign busy          = (state_q == RUN) || (state_q == DRAIN);
  assign done          = (state_q == FIN);

  always_comb begin
    row_end  = (row_q == nrows_q - ONE);
    col_end  = (col_q == ncols_q - ONE);
    line_end = colmaj_q ? row_end : col_end;
    mat_end  = row_end & col_end;
    // Reads already in flight must still fit in the FIFO when their data lands.
    issue    = (state_q == RUN) && ((cnt_q + {2'b00, tag_q}) < 3'd4);
    push     = tag_q;
    pop      = out_valid & out_ready;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    row_d      = row_q;
    col_d      = col_q;
    base_d     = base_q;
    nrows_d    = nrows_q;
    ncols_d    = ncols_q;
    colmaj_d   = colmaj_q;
    tag_d      = issue;
    tag_ll_d   = line_end;
    tag_last_d = mat_end;
    fdata_d    = fdata_q;
    fll_d      = fll_q;
    flast_d    = flast_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q + {2'b00, push} - {2'b00, pop};

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d   = base_addr;
          nrows_d  = n_rows;
          ncols_d  = n_cols;
          colmaj_d = col_major;
          addr_d   = base_addr;
          row_d    = '0;
          col_d    = '0;
          state_d  = ((n_rows == '0) || (n_cols == '0)) ? FIN : RUN;
        end
      end
      RUN: begin
        if (issue) begin
          if (mat_end) begin
            state_d = DRAIN;
          end else if (colmaj_q) begin
            if (row_end) begin
              row_d  = '0;
              col_d  = col_q + ONE;
              addr_d = base_q + col_q + ONE;
            end else begin
              row_d  = row_q + ONE;
              addr_d = addr_q + ncols_q;
            end
          end else begin
            addr_d = addr_q + ONE;
            if (col_end) begin
              col_d = '0;
              row_d = row_q + ONE;
            end else begin
              col_d = col_q + ONE;
            end
          end
        end
      end
      DRAIN: begin
        if (pop && flast_q[rptr_q]) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // RAM Q stage -> skid FIFO
    if (push) begin
      fdata_d[wptr_q] = rd_data;
      fll_d[wptr_q]   = tag_ll_q;
      flast_d[wptr_q] = tag_last_q;
      wptr_d          = wptr_q + 2'd1;
    end
    if (pop) rptr_d = rptr_q + 2'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      base_q     <= '0;
      nrows_q    <= '0;
      ncols_q    <= '0;
      colmaj_q   <= 1'b0;
      tag_q      <= 1'b0;
      tag_ll_q   <= 1'b0;
      tag_last_q <= 1'b0;
      fdata_q    <= '{default: '0};
      fll_q      <= '0;
      flast_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      row_q      <= row_d;
      col_q      <= col_d;
      base_q     <= base_d;
      nrows_q    <= nrows_d;
      ncols_q    <= ncols_d;
      colmaj_q   <= colmaj_d;
      tag_q      <= tag_d;
      tag_ll_q   <= tag_ll_d;
      tag_last_q <= tag_last_d;
      fdata_q    <= fdata_d;
      fll_q      <= fll_d;
      flast_q    <= flast_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
    end
  end
endmodule

// File: tb/tb_mat_stream_reader.sv
// Scoreboard bench for mat_stream_reader: RAM preloaded with mem[i]=i, expected elements
// derived from matrix index arithmetic and checked by a decoupled stream monitor.
module tb_mat_stream_reader;
  logic       CLK = 1'b0, RST_N = 1'b0, start = 1'b0, col_major = 1'b0, out_ready = 1'b1;
  logic [6:0] base_addr = '0, n_rows = '0, n_cols = '0, rd_addr;
  logic [7:0] rd_data, out_data;
  logic       out_valid, out_last_line, out_last, busy, done;

  mat_stream_reader #(.ADDR_LEN(6), .DATA_LEN(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .base_addr(base_addr),
    .n_rows(n_rows), .n_cols(n_cols), .col_major(col_major),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last_line(out_last_line),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  logic [7:0] ram [128];
  initial for (int i = 0; i < 128; i++) ram[i] = 8'(i);
  always @(posedge CLK) rd_data <= ram[rd_addr];

  int checks = 0, errors = 0, hs_count = 0;

  typedef struct packed { logic [7:0] d; logic ll; logic last; } elem_t;
  elem_t exp_q[$];
  elem_t held, e;
  bit    hold_prev = 1'b0;

  logic [6:0] ahist [1:300];
  bit         vhist [1:300];
  bit         bhist [1:300];
  int         done_cycle;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  always @(negedge CLK) begin
    if (RST_N && hold_prev)
      check("hold_stable", {out_valid, out_data, out_last_line, out_last}, {1'b1, held});
    hold_prev = RST_N && out_valid && !out_ready;
    held = {out_data, out_last_line, out_last};
    if (RST_N && out_valid && out_ready) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_elem: got data 0x%0h expected no element", out_data);
      end else begin
        e = exp_q.pop_front();
        check("elem", {out_data, out_last_line, out_last}, e);
      end
    end
  end

  // rmode: 0 ready high, 1 random ready, 2 ready low in cycles 3..10
  task automatic run_walk(input logic [6:0] b, input logic [6:0] nr, input logic [6:0] nc,
                          input logic cm, input int rmode, input bit ign, input int rst_at);
    int  rows = int'(nr), cols = int'(nc), hs0, a, r, c;
    bit  aborted = 1'b0;
    if (rows != 0 && cols != 0)
      for (int i = 0; i < rows * cols; i++) begin
        if (cm) begin c = i / rows; r = i % rows; end
        else    begin r = i / cols; c = i % cols; end
        a = (int'(b) + r * cols + c) % 128;
        exp_q.push_back({8'(a), cm ? (r == rows - 1) : (c == cols - 1),
                         (r == rows - 1) && (c == cols - 1)});
      end
    hs0 = hs_count;
    done_cycle = 0;
    @(posedge CLK); #1;
    base_addr = b; n_rows = nr; n_cols = nc; col_major = cm; start = 1'b1;
    out_ready = (rmode == 1) ? ($urandom_range(0, 9) < 7) : 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      case (rmode)
        1:       out_ready = ($urandom_range(0, 9) < 7);
        2:       out_ready = !(k >= 3 && k <= 10);
        default: out_ready = 1'b1;
      endcase
      if (ign) begin
        start = (k == 2);
        if (k == 2) begin
          base_addr = 7'($urandom); n_rows = 7'd1; n_cols = 7'd1; col_major = ~cm;
        end
      end
      if (k == rst_at) begin
        #1 RST_N = 1'b0;
        #1 check("async_reset_outputs",
                 {rd_addr, out_data, out_valid, out_last_line, out_last, busy, done}, 0);
        exp_q.delete();
        @(negedge CLK); #2 RST_N = 1'b1;
        aborted = 1'b1;
        break;
      end
      @(negedge CLK);
      ahist[k] = rd_addr; vhist[k] = out_valid; bhist[k] = busy;
      if (done) begin done_cycle = k; break; end
      @(posedge CLK); #1;
    end
    if (!aborted) begin
      check("done_seen", done_cycle != 0, 1);
      check("queue_drained", exp_q.size(), 0);
      check("elem_count", hs_count - hs0, rows * cols);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    check("reset_outputs", {rd_addr, out_data, out_valid, out_last_line, out_last, busy, done}, 0);
    RST_N = 1'b1;

    run_walk(7'h10, 7'd2, 7'd3, 1'b0, 0, 1'b0, 0);
    for (int k = 1; k <= 6; k++) check("rm_rd_addr", ahist[k], 16 + k - 1);
    for (int k = 1; k <= 9; k++) check("rm_out_valid", vhist[k], (k >= 3 && k <= 8));
    for (int k = 1; k <= 9; k++) check("rm_busy", bhist[k], (k <= 8));
    check("rm_done_cycle", done_cycle, 9);

    run_walk(7'h10, 7'd2, 7'd3, 1'b1, 0, 1'b0, 0);
    check("cm_done_cycle", done_cycle, 9);

    run_walk(7'h00, 7'd1, 7'd8, 1'b0, 2, 1'b0, 0);
    check("stall_rd_addr", ahist[10], 4);
    check("stall_valid", vhist[10], 1);

    run_walk(7'h7E, 7'd1, 7'd4, 1'b0, 0, 1'b0, 0);
    for (int k = 1; k <= 4; k++) check("wrap_rd_addr", ahist[k], (126 + k - 1) % 128);

    run_walk(7'h05, 7'd0, 7'd3, 1'b0, 0, 1'b0, 0);
    check("zero_rows_done", done_cycle, 1);
    check("zero_rows_valid", vhist[1], 0);
    run_walk(7'h05, 7'd3, 7'd0, 1'b1, 0, 1'b0, 0);
    check("zero_cols_done", done_cycle, 1);

    run_walk(7'h10, 7'd2, 7'd3, 1'b1, 0, 1'b1, 0);
    check("ign_start_done_cycle", done_cycle, 9);

    run_walk(7'h10, 7'd2, 7'd3, 1'b0, 0, 1'b0, 6);
    run_walk(7'h10, 7'd2, 7'd3, 1'b0, 0, 1'b0, 0);
    check("post_reset_done_cycle", done_cycle, 9);

    for (int t = 0; t < 25; t++)
      run_walk(7'($urandom), 7'($urandom_range(0, 5)), 7'($urandom_range(0, 5)),
               1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
